// File: rtl/read_module_pkg.sv
// Shared state encoding, frame geometry and timing thresholds for the
// single-wire sensor receiver.
package read_module_pkg;

   localparam int CNT_W      = 8;
   localparam int BIT_CNT_W  = 6;
   localparam int FRAME_BITS = 40;

   // Thresholds are in clock cycles (10 us clock).
   localparam logic [CNT_W-1:0] RESP_MIN   = 8'd6;
   localparam logic [CNT_W-1:0] ONE_THRESH = 8'd5;
   localparam logic [CNT_W-1:0] TIMEOUT    = 8'd12;

   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 6'(FRAME_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] SEND_LAST = 6'(FRAME_BITS);

   typedef enum logic [2:0] {
      IDLE,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK,
      SEND
   } state_t;

   // Byte4 must equal the carry-discarding sum of bytes 0..3.
   function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
      logic [7:0] w_sum;
      w_sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return (w_sum == frame[7:0]);
   endfunction

endpackage

// File: rtl/read_module_sync.sv
// Two-flop synchronizer for the sensor line followed by a registered edge
// detector producing one-cycle rise and fall pulses.
module read_module_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_data,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   // The line idles high, so the chain resets high to avoid a false fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_data;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/read_module.sv
// Single-wire sensor receiver: validates the response preamble, decodes the
// 40-bit frame from pulse widths, checks the checksum and replays good frames.
module read_module
   import read_module_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_data,
   output logic out_data
);

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BIT_CNT_W-1:0]  r_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_out;

   logic                  w_rise;
   logic                  w_fall;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic                  w_timeout;

   read_module_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_data (in_data),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // r_cnt holds the cycles elapsed since the edge that entered the state.
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 8'd1;
   assign w_timeout = (r_cnt > TIMEOUT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_out     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_out <= 1'b0;
               r_cnt <= '0;
               if (w_fall) begin
                  r_state <= RESP_LOW;
                  r_cnt   <= 8'd1;
               end
            end

            RESP_LOW: begin
               if (w_timeout) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_rise) begin
                  if (r_cnt >= RESP_MIN) begin
                     r_state <= RESP_HIGH;
                     r_cnt   <= 8'd1;
                  end else begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            RESP_HIGH: begin
               if (w_timeout) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_fall) begin
                  if (r_cnt >= RESP_MIN) begin
                     r_state   <= BIT_LOW;
                     r_cnt     <= 8'd1;
                     r_bit_cnt <= '0;
                     r_shift   <= '0;
                  end else begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            BIT_LOW: begin
               if (w_timeout) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_shift <= '0;
               end else if (w_rise) begin
                  r_state <= BIT_HIGH;
                  r_cnt   <= 8'd1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            BIT_HIGH: begin
               if (w_timeout) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_shift <= '0;
               end else if (w_fall) begin
                  r_shift   <= {r_shift[FRAME_BITS-2:0], (r_cnt >= ONE_THRESH)};
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  r_cnt     <= 8'd1;
                  r_state   <= (r_bit_cnt == LAST_BIT) ? CHECK : BIT_LOW;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            CHECK: begin
               r_cnt <= '0;
               if (checksum_ok(r_shift)) begin
                  r_state   <= SEND;
                  r_out     <= 1'b1;
                  r_bit_cnt <= '0;
               end else begin
                  r_state <= IDLE;
                  r_shift <= '0;
               end
            end

            SEND: begin
               if (r_bit_cnt == SEND_LAST) begin
                  r_state <= IDLE;
                  r_out   <= 1'b0;
               end else begin
                  r_out     <= r_shift[FRAME_BITS-1];
                  r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 6'd1;
               end
            end

            default: begin
               r_state <= IDLE;
               r_out   <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign out_data = r_out;

endmodule

// File: tb/tb_read_module.sv
// Directed bench for read_module: drives sensor waveforms with chosen pulse
// widths and compares the replayed serial frame against hand-computed values.
module tb_read_module;
   import read_module_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic in_data;
   logic out_data;

   int checks   = 0;
   int failures = 0;
   logic [39:0] exp_q[$];

   read_module dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .out_data (out_data)
   );

   always #5 clk = ~clk;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: run exceeded time limit after %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic hold(input logic val, input int n);
      in_data = val;
      repeat (n) @(negedge clk);
   endtask

   // Bit i (0 = first received) high width is b1/b0 by data, or long_w at long_idx.
   task automatic send_frame(input logic [39:0] f, input int n_bits,
                             input int rl, input int rh, input int bl,
                             input int b0, input int b1,
                             input int long_idx, input int long_w);
      int w;
      hold(1'b0, rl);
      hold(1'b1, rh);
      for (int i = 0; i < n_bits; i++) begin
         if (i == long_idx) w = long_w;
         else if (f[39-i])  w = b1;
         else               w = b0;
         hold(1'b0, bl);
         hold(1'b1, w);
      end
      if (n_bits == 40) begin
         hold(1'b0, 2);
         in_data = 1'b1;
      end
   endtask

   task automatic send_nominal(input logic [39:0] f);
      send_frame(f, 40, 8, 8, 5, 3, 7, -1, 0);
   endtask

   task automatic expect_frame();
      logic [39:0] exp_f;
      logic [39:0] got;
      int k;
      bit seen;
      exp_f = exp_q.pop_front();
      seen  = 1'b0;
      k     = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_data === 1'b1) begin
            seen = 1'b1;
            k    = i;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL start_bit: got no start bit in 20 cycles, expected frame %h", exp_f);
         return;
      end
      checks++;
      if (k != 2) begin
         failures++;
         $display("FAIL start_latency: got %0d, expected 2 (frame %h)", k, exp_f);
      end
      got = '0;
      for (int b = 39; b >= 0; b--) begin
         @(negedge clk);
         got[b] = out_data;
      end
      checks++;
      if (got !== exp_f) begin
         failures++;
         $display("FAIL frame_data: got %h, expected %h", got, exp_f);
      end
      @(negedge clk);
      checks++;
      if (out_data !== 1'b0) begin
         failures++;
         $display("FAIL send_end: out_data got %b, expected 0 after 41 cycles", out_data);
      end
      checks++;
      if (dut.r_state !== IDLE) begin
         failures++;
         $display("FAIL send_idle: state got %0d, expected %0d", dut.r_state, IDLE);
      end
   endtask

   task automatic expect_silent(input int n, input string name);
      int highs;
      highs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (out_data !== 1'b0) highs++;
      end
      checks++;
      if (highs != 0) begin
         failures++;
         $display("FAIL %s_silent: out_data high for %0d cycles, expected 0", name, highs);
      end
      checks++;
      if (dut.r_state !== IDLE) begin
         failures++;
         $display("FAIL %s_idle: state got %0d, expected %0d", name, dut.r_state, IDLE);
      end
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      in_data = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (out_data !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: got %b, expected 0", out_data);
      end
      checks++;
      if (dut.r_state !== IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d, expected %0d", dut.r_state, IDLE);
      end
      checks++;
      if (dut.r_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_cnt: got %0d, expected 0", dut.r_cnt);
      end
      checks++;
      if (dut.u_sync.r_meta !== 1'b1 || dut.u_sync.r_sync !== 1'b1) begin
         failures++;
         $display("FAIL reset_sync: got %b%b, expected 11", dut.u_sync.r_meta, dut.u_sync.r_sync);
      end
      rst = 1'b1;
      hold(1'b1, 10);
      expect_silent(5, "post_reset");
   endtask

   task automatic test_line_low();
      hold(1'b1, 10);
      in_data = 1'b0;
      expect_silent(1000, "line_low");
      hold(1'b1, 10);
   endtask

   task automatic test_valid_frame();
      hold(1'b1, 10);
      exp_q.push_back(40'h3700190050);
      send_nominal(40'h3700190050);
      expect_frame();
   endtask

   task automatic test_bad_checksum();
      hold(1'b1, 10);
      send_nominal(40'h3700190051);
      expect_silent(60, "bad_csum");
      exp_q.push_back(40'h123400569C);
      send_nominal(40'h123400569C);
      expect_frame();
   endtask

   task automatic test_checksum_wrap();
      hold(1'b1, 10);
      exp_q.push_back(40'hFF01000000);
      send_nominal(40'hFF01000000);
      expect_frame();
   endtask

   // Widths sitting exactly on RESP_MIN, ONE_THRESH and TIMEOUT.
   task automatic test_thresholds();
      hold(1'b1, 10);
      exp_q.push_back(40'hA55A0FF0FE);
      send_frame(40'hA55A0FF0FE, 40, 6, 6, 12, 4, 5, -1, 0);
      expect_frame();
      hold(1'b1, 10);
      exp_q.push_back(40'h010203040A);
      send_frame(40'h010203040A, 40, 8, 8, 5, 2, 12, -1, 0);
      expect_frame();
      hold(1'b1, 10);
      send_frame(40'h3700190050, 40, 8, 8, 5, 3, 7, 5, 13);
      expect_silent(60, "timeout_13");
   endtask

   task automatic test_short_response();
      hold(1'b1, 10);
      send_frame(40'h3700190050, 40, 5, 8, 5, 3, 7, -1, 0);
      expect_silent(60, "short_resp");
   endtask

   task automatic test_timeout_bit();
      hold(1'b1, 10);
      send_frame(40'h3700190050, 40, 8, 8, 5, 3, 7, 12, 20);
      expect_silent(60, "bit12_long");
      exp_q.push_back(40'h3700190050);
      send_nominal(40'h3700190050);
      expect_frame();
   endtask

   task automatic test_reset_mid_frame();
      hold(1'b1, 10);
      send_frame(40'h3700190050, 20, 8, 8, 5, 3, 7, -1, 0);
      hold(1'b0, 5);
      hold(1'b1, 3);
      rst = 1'b0;
      #1;
      checks++;
      if (out_data !== 1'b0) begin
         failures++;
         $display("FAIL mid_frame_rst_out: got %b, expected 0", out_data);
      end
      checks++;
      if (dut.r_state !== IDLE || dut.r_bit_cnt !== 6'd0) begin
         failures++;
         $display("FAIL mid_frame_rst_state: state %0d bits %0d, expected %0d and 0",
                  dut.r_state, dut.r_bit_cnt, IDLE);
      end
      @(negedge clk);
      rst = 1'b1;
      hold(1'b1, 10);
      exp_q.push_back(40'h123400569C);
      send_nominal(40'h123400569C);
      expect_frame();
   endtask

   task automatic test_reset_mid_send();
      bit seen;
      hold(1'b1, 10);
      send_nominal(40'hFF01000000);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_data === 1'b1) seen = 1'b1;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (!seen || out_data !== 1'b1) begin
         failures++;
         $display("FAIL mid_send_pre: seen %b out_data %b, expected 1 and 1", seen, out_data);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (out_data !== 1'b0) begin
         failures++;
         $display("FAIL mid_send_async: got %b, expected 0", out_data);
      end
      @(negedge clk);
      rst = 1'b1;
      hold(1'b1, 10);
      expect_silent(20, "after_send_rst");
      exp_q.push_back(40'hFF01000000);
      send_nominal(40'hFF01000000);
      expect_frame();
   endtask

   task automatic test_back_to_back();
      logic [39:0] frames [3];
      frames[0] = 40'h0A0B0C0D2E;
      frames[1] = 40'h8080808000;
      frames[2] = 40'h0000000000;
      hold(1'b1, 10);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(frames[i]);
         send_nominal(frames[i]);
         expect_frame();
      end
   endtask

   initial begin
      rst     = 1'b0;
      in_data = 1'b1;
      test_reset();
      test_line_low();
      test_valid_frame();
      test_bad_checksum();
      test_checksum_wrap();
      test_thresholds();
      test_short_response();
      test_timeout_bit();
      test_reset_mid_frame();
      test_reset_mid_send();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
